// File: rtl/store_size_sequencer_if.sv
// Control-unit and data-memory signals of the store size sequencer.
// The master side is the control unit plus memory; the slave side is the sequencer.
interface store_size_sequencer_if;
    logic        start;
    logic [1:0]  store_size_control;
    logic [31:0] address;
    logic [31:0] reg_data;
    logic [31:0] mem_data_in;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_data_out;
    logic        busy;
    logic        done;
    logic        misalign;

    modport master (
        output start, store_size_control, address, reg_data, mem_data_in,
        input  mem_addr, mem_wr, mem_data_out, busy, done, misalign
    );

    modport slave (
        input  start, store_size_control, address, reg_data, mem_data_in,
        output mem_addr, mem_wr, mem_data_out, busy, done, misalign
    );
endinterface

// File: rtl/store_size_sequencer.sv
// Word/halfword/byte store sequencer; sub-word stores read-modify-write the low lanes.
// Optional alignment fault detection is enabled by defining STORE_ALIGN_CHECK_EN.
module store_size_sequencer #(
    parameter int READ_LATENCY = 1    // legal range 1..7
) (
    input  logic                   clk,
    input  logic                   reset,
    store_size_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] WAIT_LOAD = 3'(READ_LATENCY - 1);

    state_t      state_reg;
    logic [31:0] data_reg;
    logic [3:0]  lane_sel_reg;
    logic [2:0]  wait_cnt_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_data_out_reg;
    logic        mem_wr_reg;
    logic        done_reg;
    logic        misalign_reg;

    logic [3:0]  lane_sel_next;
    logic [31:0] merged;
    logic        fault;

    // A set bit means the lane comes from the register, a clear bit keeps memory.
    always_comb begin
        lane_sel_next = 4'b0000;
        case (bus.store_size_control)
            2'd1:    lane_sel_next = 4'b1111;
            2'd2:    lane_sel_next = 4'b0011;
            2'd3:    lane_sel_next = 4'b0001;
            default: lane_sel_next = 4'b0000;
        endcase
    end

`ifdef STORE_ALIGN_CHECK_EN
    assign fault = ((bus.store_size_control == 2'd1) && (bus.address[1:0] != 2'b00)) ||
                   ((bus.store_size_control == 2'd2) && bus.address[0]);
`else
    assign fault = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[8*gi +: 8] = lane_sel_reg[gi] ? data_reg[8*gi +: 8]
                                                        : bus.mem_data_in[8*gi +: 8];
        end
    endgenerate

    // Outputs are loaded together with the state they belong to, so they stay Moore.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= S_IDLE;
            data_reg         <= '0;
            lane_sel_reg     <= '0;
            wait_cnt_reg     <= '0;
            mem_addr_reg     <= '0;
            mem_data_out_reg <= '0;
            mem_wr_reg       <= 1'b0;
            done_reg         <= 1'b0;
            misalign_reg     <= 1'b0;
        end else begin
            mem_wr_reg       <= 1'b0;
            done_reg         <= 1'b0;
            misalign_reg     <= 1'b0;
            mem_data_out_reg <= '0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        data_reg     <= bus.reg_data;
                        lane_sel_reg <= lane_sel_next;
                        if (bus.store_size_control == 2'd0) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end else if (fault) begin
                            state_reg    <= S_DONE;
                            done_reg     <= 1'b1;
                            misalign_reg <= 1'b1;
                        end else if (bus.store_size_control == 2'd1) begin
                            state_reg        <= S_WRITE;
                            mem_addr_reg     <= bus.address;
                            mem_wr_reg       <= 1'b1;
                            mem_data_out_reg <= bus.reg_data;
                        end else begin
                            state_reg    <= S_READ;
                            mem_addr_reg <= bus.address;
                        end
                    end
                end
                S_READ: begin
                    state_reg    <= S_WAIT;
                    wait_cnt_reg <= WAIT_LOAD;
                end
                S_WAIT: begin
                    // Read data is valid in the last WAIT cycle and captured on its closing edge.
                    if (wait_cnt_reg == 3'd0) begin
                        state_reg        <= S_WRITE;
                        mem_wr_reg       <= 1'b1;
                        mem_data_out_reg <= merged;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 3'd1;
                    end
                end
                S_WRITE: begin
                    state_reg    <= S_DONE;
                    mem_addr_reg <= '0;
                    done_reg     <= 1'b1;
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg    <= S_IDLE;
                    mem_addr_reg <= '0;
                end
            endcase
        end
    end

    assign bus.mem_addr     = mem_addr_reg;
    assign bus.mem_wr       = mem_wr_reg;
    assign bus.mem_data_out = mem_data_out_reg;
    assign bus.busy         = (state_reg != S_IDLE);
    assign bus.done         = done_reg;
    assign bus.misalign     = misalign_reg;

endmodule

// File: tb/tb_store_size_sequencer.sv
// Directed bench for store_size_sequencer: DUT a uses READ_LATENCY=1, DUT b uses 3.
// Memory is modelled as a fixed lookup table behind a read-latency pipeline.
module tb_store_size_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [31:0] addr = '0;
    logic [31:0] data = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    store_size_sequencer_if if_a ();
    store_size_sequencer_if if_b ();

    store_size_sequencer #(.READ_LATENCY(1)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
    store_size_sequencer #(.READ_LATENCY(3)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));

    function automatic logic [31:0] mem_lookup(input logic [31:0] a);
        case (a)
            32'h0000_0020: return 32'h1122_3344;
            32'h0000_0013: return 32'h5566_7788;
            default:       return 32'hA5A5_A5A5;
        endcase
    endfunction

    logic [31:0] pipe_a;
    logic [31:0] pipe_b [3];
    always @(posedge clk) begin
        pipe_a    <= mem_lookup(if_a.mem_addr);
        pipe_b[0] <= mem_lookup(if_b.mem_addr);
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end

    assign if_a.start              = start & ~sel;
    assign if_b.start              = start & sel;
    assign if_a.store_size_control = size;
    assign if_b.store_size_control = size;
    assign if_a.address            = addr;
    assign if_b.address            = addr;
    assign if_a.reg_data           = data;
    assign if_b.reg_data           = data;
    assign if_a.mem_data_in        = pipe_a;
    assign if_b.mem_data_in        = pipe_b[2];

    logic        o_busy, o_done, o_wr, o_mis;
    logic [31:0] o_addr, o_wdata;
    assign o_busy  = sel ? if_b.busy : if_a.busy;
    assign o_done  = sel ? if_b.done : if_a.done;
    assign o_wr    = sel ? if_b.mem_wr : if_a.mem_wr;
    assign o_mis   = sel ? if_b.misalign : if_a.misalign;
    assign o_addr  = sel ? if_b.mem_addr : if_a.mem_addr;
    assign o_wdata = sel ? if_b.mem_data_out : if_a.mem_data_out;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    // Issues one store from cycle 0 and checks the full trace against hand-computed values.
    // exp_wr_cyc = 0 means no write may occur.
    task automatic run_store(input string name, input logic dut, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] d,
                             input int exp_wr_cyc, input logic [31:0] exp_wdata,
                             input int exp_done_cyc, input logic exp_mis);
        int          wr_cnt = 0;
        int          wr_cyc = 0;
        int          done_cyc = -1;
        logic [31:0] wr_addr = '0;
        logic [31:0] wr_data = '0;
        logic        mis_at_done = 1'b0;
        logic        addr_seen = 1'b0;
        logic        stray = 1'b0;
        logic [31:0] addr_at_done = '0;
        sel   = dut;
        size  = sz;
        addr  = a;
        data  = d;
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) start = 1'b0;
            if (o_addr != 32'h0) addr_seen = 1'b1;
            if (!o_wr && o_wdata != 32'h0) stray = 1'b1;
            if (o_wr) begin
                wr_cnt++;
                if (wr_cyc == 0) begin
                    wr_cyc  = c;
                    wr_addr = o_addr;
                    wr_data = o_wdata;
                end
            end
            if (o_done) begin
                done_cyc     = c;
                mis_at_done  = o_mis;
                addr_at_done = o_addr;
                break;
            end
        end
        @(posedge clk);
        #1;
        $display("store %s: size=%0d addr=0x%08h wr_cyc=%0d data=0x%08h done_cyc=%0d misalign=%0b",
                 name, sz, a, wr_cyc, wr_data, done_cyc, mis_at_done);
        check_value({name, "/wr_cnt"}, 32'(wr_cnt), (exp_wr_cyc != 0) ? 32'd1 : 32'd0);
        check_value({name, "/wr_cyc"}, 32'(wr_cyc), 32'(exp_wr_cyc));
        check_value({name, "/wr_addr"}, wr_addr, (exp_wr_cyc != 0) ? a : 32'h0);
        check_value({name, "/wr_data"}, wr_data, exp_wdata);
        check_value({name, "/done_cyc"}, 32'(done_cyc), 32'(exp_done_cyc));
        check_value({name, "/misalign"}, 32'(mis_at_done), 32'(exp_mis));
        check_value({name, "/addr_used"}, 32'(addr_seen), (exp_wr_cyc != 0) ? 32'd1 : 32'd0);
        check_value({name, "/addr_at_done"}, addr_at_done, 32'h0);
        check_value({name, "/stray_data"}, 32'(stray), 32'd0);
        check_value({name, "/busy_after"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        int wr_cnt;
        int done_cyc;
        int budget;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            check_value($sformatf("reset%0d/busy", s), 32'(o_busy), 32'd0);
            check_value($sformatf("reset%0d/done", s), 32'(o_done), 32'd0);
            check_value($sformatf("reset%0d/mem_wr", s), 32'(o_wr), 32'd0);
            check_value($sformatf("reset%0d/misalign", s), 32'(o_mis), 32'd0);
            check_value($sformatf("reset%0d/mem_addr", s), o_addr, 32'h0);
            check_value($sformatf("reset%0d/mem_data_out", s), o_wdata, 32'h0);
        end

        run_store("word_l1", 1'b0, 2'd1, 32'h10, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 2, 1'b0);
        run_store("word_l3", 1'b1, 2'd1, 32'h10, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 2, 1'b0);
        run_store("half_l1", 1'b0, 2'd2, 32'h20, 32'hAAAA_BBBB, 3, 32'h1122_BBBB, 4, 1'b0);
        run_store("byte_l3", 1'b1, 2'd3, 32'h20, 32'h0000_00CC, 5, 32'h1122_33CC, 6, 1'b0);
        run_store("half_l3", 1'b1, 2'd2, 32'h20, 32'h1234_5678, 5, 32'h1122_5678, 6, 1'b0);
        run_store("byte_l1", 1'b0, 2'd3, 32'h20, 32'hFFFF_FF01, 3, 32'h1122_3301, 4, 1'b0);
        run_store("size0", 1'b0, 2'd0, 32'h44, 32'h1111_1111, 0, 32'h0, 1, 1'b0);

`ifdef STORE_ALIGN_CHECK_EN
        run_store("half_mis", 1'b0, 2'd2, 32'h13, 32'hAAAA_BBBB, 0, 32'h0, 1, 1'b1);
        run_store("word_mis", 1'b0, 2'd1, 32'h12, 32'hAAAA_BBBB, 0, 32'h0, 1, 1'b1);
`else
        run_store("half_mis", 1'b0, 2'd2, 32'h13, 32'hAAAA_BBBB, 3, 32'h5566_BBBB, 4, 1'b0);
`endif

        // start held high: one write per store, next store accepted after DONE
        sel   = 1'b0;
        size  = 2'd3;
        addr  = 32'h20;
        data  = 32'h0000_00CC;
        start = 1'b1;
        wr_cnt   = 0;
        done_cyc = -1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (o_wr) wr_cnt++;
            if (o_done && done_cyc < 0) done_cyc = c;
            if (done_cyc > 0 && c == done_cyc + 1) break;
        end
        $display("held_start: first store wr_cnt=%0d done_cyc=%0d", wr_cnt, done_cyc);
        check_value("held/done_cyc", 32'(done_cyc), 32'd4);
        check_value("held/wr_cnt", 32'(wr_cnt), 32'd1);
        check_value("held/idle_gap_busy", 32'(o_busy), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check_value("held/second_busy", 32'(o_busy), 32'd1);
        check_value("held/second_addr", o_addr, 32'h20);
        wr_cnt = 0;
        budget = 0;
        while (!o_done && budget < 20) begin
            @(posedge clk);
            #1;
            if (o_wr) wr_cnt++;
            budget++;
        end
        $display("held_start: second store wr_cnt=%0d cycles=%0d", wr_cnt, budget);
        check_value("held/second_done", 32'(o_done), 32'd1);
        check_value("held/second_wr_cnt", 32'(wr_cnt), 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // reset during WAIT drops the store
        sel   = 1'b1;
        size  = 2'd3;
        addr  = 32'h20;
        data  = 32'h0000_00CC;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check_value("rst_wait/busy_before", 32'(o_busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_value("rst_wait/busy", 32'(o_busy), 32'd0);
        check_value("rst_wait/mem_addr", o_addr, 32'h0);
        check_value("rst_wait/done", 32'(o_done), 32'd0);
        wr_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (o_wr) wr_cnt++;
            @(posedge clk);
            #1;
        end
        $display("rst_wait: writes after reset=%0d", wr_cnt);
        check_value("rst_wait/wr_cnt", 32'(wr_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
